// File: rtl/bus_requester.sv
// Client-side requester for a two-way grant arbiter: buffers words in a FIFO,
// requests the bus, and sends a burst of up to BURST_LEN words per grant.
module bus_requester #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 15
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     req,
   input  logic                     gnt,
   output logic                     bus_valid,
   output logic [DATA_W-1:0]        bus_data,
   output logic                     busy,
   output logic                     timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [BW-1:0]     beat;
   logic [TW-1:0]     wait_cnt;
   logic              pop;
   logic              push_ok;
   logic              has_data;

   // A word only moves while we own the bus and actually hold data.
   assign has_data  = (count != '0);
   assign bus_valid = (state == XFER) && gnt && has_data;
   assign pop       = bus_valid;
   assign push_ok   = push && (!full || pop);
   assign full      = (count == CW'(DEPTH));
   assign bus_data  = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !pop;
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push_ok) begin
            count <= count - CW'(1);
         end
      end
   end

   // Request/burst controller; the count==1 release test deliberately looks
   // at the pre-push count so a late push never stretches the burst.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         req      <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         beat     <= '0;
         wait_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (has_data) begin
                  state    <= REQ;
                  req      <= 1'b1;
                  busy     <= 1'b1;
                  wait_cnt <= '0;
               end
            end
            REQ: begin
               if (gnt) begin
                  state <= XFER;
                  beat  <= '0;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  state   <= RELEASE;
                  req     <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            XFER: begin
               if (!gnt) begin
                  state    <= REQ;
                  beat     <= '0;
                  wait_cnt <= '0;
               end else if (!has_data) begin
                  state <= RELEASE;
                  req   <= 1'b0;
               end else begin
                  beat <= beat + BW'(1);
                  if (beat == BW'(BURST_LEN - 1) || count == CW'(1)) begin
                     state <= RELEASE;
                     req   <= 1'b0;
                  end
               end
            end
            RELEASE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: single-instance scenarios plus two
// instances sharing a small grant arbiter model.
module tb_bus_requester;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Instance A: default parameters
   logic       a_push, a_full, a_overflow, a_req, a_gnt, a_valid, a_busy, a_timeout;
   logic [7:0] a_data, a_bus;
   logic [2:0] a_count;

   // Instance B: BURST_LEN = 2
   logic       b_push, b_full, b_overflow, b_req, b_gnt, b_valid, b_busy, b_timeout;
   logic [7:0] b_data, b_bus;
   logic [2:0] b_count;

   // Requesters 0 and 1 on the arbiter model
   logic       r0_push, r0_full, r0_overflow, r0_req, r0_gnt, r0_valid, r0_busy, r0_timeout;
   logic [7:0] r0_data, r0_bus;
   logic [2:0] r0_count;
   logic       r1_push, r1_full, r1_overflow, r1_req, r1_gnt, r1_valid, r1_busy, r1_timeout;
   logic [7:0] r1_data, r1_bus;
   logic [2:0] r1_count;

   bus_requester dut_a (
      .clock(clock), .reset(reset), .push(a_push), .push_data(a_data), .full(a_full),
      .count(a_count), .overflow(a_overflow), .req(a_req), .gnt(a_gnt), .bus_valid(a_valid),
      .bus_data(a_bus), .busy(a_busy), .timeout(a_timeout));

   bus_requester #(.BURST_LEN(2)) dut_b (
      .clock(clock), .reset(reset), .push(b_push), .push_data(b_data), .full(b_full),
      .count(b_count), .overflow(b_overflow), .req(b_req), .gnt(b_gnt), .bus_valid(b_valid),
      .bus_data(b_bus), .busy(b_busy), .timeout(b_timeout));

   bus_requester dut_r0 (
      .clock(clock), .reset(reset), .push(r0_push), .push_data(r0_data), .full(r0_full),
      .count(r0_count), .overflow(r0_overflow), .req(r0_req), .gnt(r0_gnt), .bus_valid(r0_valid),
      .bus_data(r0_bus), .busy(r0_busy), .timeout(r0_timeout));

   bus_requester dut_r1 (
      .clock(clock), .reset(reset), .push(r1_push), .push_data(r1_data), .full(r1_full),
      .count(r1_count), .overflow(r1_overflow), .req(r1_req), .gnt(r1_gnt), .bus_valid(r1_valid),
      .bus_data(r1_bus), .busy(r1_busy), .timeout(r1_timeout));

   // Registered arbiter: requester 0 has priority, grant held until owner drops req
   always_ff @(posedge clock) begin
      if (reset) begin
         r0_gnt <= 1'b0;
         r1_gnt <= 1'b0;
      end else if (r0_gnt && !r0_req) begin
         r0_gnt <= 1'b0;
      end else if (r1_gnt && !r1_req) begin
         r1_gnt <= 1'b0;
      end else if (!r0_gnt && !r1_gnt) begin
         if (r0_req) r0_gnt <= 1'b1;
         else if (r1_req) r1_gnt <= 1'b1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      a_push  = 1'b0; b_push = 1'b0; r0_push = 1'b0; r1_push = 1'b0;
      a_data  = '0;   b_data = '0;   r0_data = '0;   r1_data = '0;
      a_gnt   = 1'b0; b_gnt  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      reset  = 1'b1;
      a_push = 1'b1;
      a_data = 8'hEE;
      a_gnt  = 1'b1;
      step();
      step();
      settle();
      checks++;
      if ({a_req, a_valid, a_full, a_overflow, a_timeout, a_busy} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b want 000000", {a_req, a_valid, a_full, a_overflow, a_timeout, a_busy});
      end
      checks++;
      if (a_count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_count: got %0d want 0", a_count);
      end
      apply_reset();
   endtask

   task automatic test_basic_burst();
      int exp_req[7]  = '{0, 0, 1, 1, 1, 0, 0};
      int exp_val[7]  = '{0, 0, 0, 1, 1, 0, 0};
      int exp_busy[7] = '{0, 0, 1, 1, 1, 1, 0};
      logic [7:0] exp_d[7] = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00};
      apply_reset();
      a_gnt = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         a_push = (c < 2);
         a_data = (c == 0) ? 8'hA1 : 8'hA2;
         settle();
         checks++;
         if (a_req !== exp_req[c][0] || a_valid !== exp_val[c][0] || a_busy !== exp_busy[c][0]) begin
            errors++;
            $display("[TB] FAIL basic_ctrl cyc%0d: got req=%b valid=%b busy=%b want req=%0d valid=%0d busy=%0d",
                     c, a_req, a_valid, a_busy, exp_req[c], exp_val[c], exp_busy[c]);
         end
         if (exp_val[c] == 1) begin
            checks++;
            if (a_bus !== exp_d[c]) begin
               errors++;
               $display("[TB] FAIL basic_data cyc%0d: got %h want %h", c, a_bus, exp_d[c]);
            end
         end
      end
      checks++;
      if (a_count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL basic_count_end: got %0d want 0", a_count);
      end
   endtask

   task automatic test_back_to_back();
      int exp_req[11] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
      int exp_val[11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
      logic [7:0] exp_d[11] = '{8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'hB3, 8'hB4, 8'h00};
      apply_reset();
      b_gnt = 1'b1;
      for (int c = 0; c < 11; c++) begin
         step();
         b_push = (c < 4);
         b_data = 8'hB1 + 8'(c);
         settle();
         checks++;
         if (b_req !== exp_req[c][0] || b_valid !== exp_val[c][0]) begin
            errors++;
            $display("[TB] FAIL b2b_ctrl cyc%0d: got req=%b valid=%b want req=%0d valid=%0d",
                     c, b_req, b_valid, exp_req[c], exp_val[c]);
         end
         if (exp_val[c] == 1) begin
            checks++;
            if (b_bus !== exp_d[c]) begin
               errors++;
               $display("[TB] FAIL b2b_data cyc%0d: got %h want %h", c, b_bus, exp_d[c]);
            end
         end
      end
      checks++;
      if (b_count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL b2b_count_end: got %0d want 0", b_count);
      end
   endtask

   task automatic test_overflow();
      int exp_cnt[16]  = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 1, 1, 1, 0};
      int exp_full[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      int exp_ovf[16]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int exp_val[16]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
      int exp_req[16]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0};
      logic [7:0] exp_d[16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h31,
                                8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h36, 8'h00};
      apply_reset();
      for (int c = 0; c < 16; c++) begin
         step();
         a_gnt  = (c >= 6);
         a_push = (c < 5) || (c == 7);
         a_data = (c == 7) ? 8'h36 : 8'h31 + 8'(c);
         settle();
         checks++;
         if (a_count !== 3'(exp_cnt[c]) || a_full !== exp_full[c][0] || a_overflow !== exp_ovf[c][0]) begin
            errors++;
            $display("[TB] FAIL ovf_fifo cyc%0d: got count=%0d full=%b ovf=%b want count=%0d full=%0d ovf=%0d",
                     c, a_count, a_full, a_overflow, exp_cnt[c], exp_full[c], exp_ovf[c]);
         end
         checks++;
         if (a_req !== exp_req[c][0] || a_valid !== exp_val[c][0]) begin
            errors++;
            $display("[TB] FAIL ovf_ctrl cyc%0d: got req=%b valid=%b want req=%0d valid=%0d",
                     c, a_req, a_valid, exp_req[c], exp_val[c]);
         end
         if (exp_val[c] == 1) begin
            checks++;
            if (a_bus !== exp_d[c]) begin
               errors++;
               $display("[TB] FAIL ovf_data cyc%0d: got %h want %h", c, a_bus, exp_d[c]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic want_req, want_to;
      apply_reset();
      a_gnt = 1'b0;
      for (int c = 0; c < 35; c++) begin
         step();
         a_push = (c == 0);
         a_data = 8'h44;
         settle();
         want_req = (c >= 2 && c <= 16) || (c >= 19 && c <= 33);
         want_to  = (c == 17) || (c == 34);
         checks++;
         if (a_req !== want_req || a_timeout !== want_to || a_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout cyc%0d: got req=%b to=%b valid=%b want req=%b to=%b valid=0",
                     c, a_req, a_timeout, a_valid, want_req, want_to);
         end
      end
   endtask

   task automatic test_preempt();
      int exp_gnt[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
      int exp_req[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
      int exp_val[9] = '{0, 0, 0, 1, 0, 0, 1, 1, 0};
      logic [7:0] exp_d[9] = '{8'h00, 8'h00, 8'h00, 8'h51, 8'h00, 8'h00, 8'h52, 8'h53, 8'h00};
      apply_reset();
      for (int c = 0; c < 9; c++) begin
         step();
         a_gnt  = exp_gnt[c][0];
         a_push = (c < 3);
         a_data = 8'h51 + 8'(c);
         settle();
         checks++;
         if (a_req !== exp_req[c][0] || a_valid !== exp_val[c][0]) begin
            errors++;
            $display("[TB] FAIL preempt_ctrl cyc%0d: got req=%b valid=%b want req=%0d valid=%0d",
                     c, a_req, a_valid, exp_req[c], exp_val[c]);
         end
         if (exp_val[c] == 1) begin
            checks++;
            if (a_bus !== exp_d[c]) begin
               errors++;
               $display("[TB] FAIL preempt_data cyc%0d: got %h want %h", c, a_bus, exp_d[c]);
            end
         end
      end
      checks++;
      if (a_count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL preempt_count_end: got %0d want 0", a_count);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      a_gnt = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         a_push = (c < 3);
         a_data = 8'h61 + 8'(c);
         settle();
      end
      checks++;
      if (a_valid !== 1'b1 || a_bus !== 8'h61) begin
         errors++;
         $display("[TB] FAIL midrst_pre: got valid=%b data=%h want valid=1 data=61", a_valid, a_bus);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (a_req !== 1'b0 || a_valid !== 1'b0 || a_count !== 3'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_after%0d: got req=%b valid=%b count=%0d busy=%b want 0 0 0 0",
                     c, a_req, a_valid, a_count, a_busy);
         end
         step();
      end
   endtask

   task automatic test_two_requesters();
      int first0 = -1, last0 = -1, first1 = -1, n0 = 0, n1 = 0, overlap = 0;
      logic [7:0] got0[2];
      logic [7:0] got1[2];
      got0[0] = '0; got0[1] = '0; got1[0] = '0; got1[1] = '0;
      apply_reset();
      for (int c = 0; c < 30; c++) begin
         step();
         r0_push = (c < 2);
         r1_push = (c < 2);
         r0_data = 8'h70 + 8'(c);
         r1_data = 8'h80 + 8'(c);
         settle();
         if (r0_valid && r1_valid) overlap++;
         if (r0_valid) begin
            if (first0 < 0) first0 = c;
            last0 = c;
            if (n0 < 2) got0[n0] = r0_bus;
            n0++;
         end
         if (r1_valid) begin
            if (first1 < 0) first1 = c;
            if (n1 < 2) got1[n1] = r1_bus;
            n1++;
         end
      end
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("[TB] FAIL dual_overlap: got %0d both-valid cycles want 0", overlap);
      end
      checks++;
      if (first0 !== 4 || first1 !== 9) begin
         errors++;
         $display("[TB] FAIL dual_order: got first0=%0d first1=%0d want 4 9", first0, first1);
      end
      checks++;
      if (!(last0 < first1)) begin
         errors++;
         $display("[TB] FAIL dual_sequence: got last0=%0d first1=%0d want last0<first1", last0, first1);
      end
      checks++;
      if (n0 !== 2 || got0[0] !== 8'h70 || got0[1] !== 8'h71) begin
         errors++;
         $display("[TB] FAIL dual_r0_words: got n=%0d %h %h want 2 70 71", n0, got0[0], got0[1]);
      end
      checks++;
      if (n1 !== 2 || got1[0] !== 8'h80 || got1[1] !== 8'h81) begin
         errors++;
         $display("[TB] FAIL dual_r1_words: got n=%0d %h %h want 2 80 81", n1, got1[0], got1[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_burst();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_preempt();
      test_reset_mid_burst();
      test_two_requesters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
